disp_in: RTL and testbench
==========================

Name: disp_in

Overview:
- Video capture front end: the writer-side counterpart of the XGA display output path.
- Accepts a parallel 24-bit RGB pixel stream with DE/VSYNC from an external XGA source on PCK.
- Pushes active pixels into the pixel FIFO and pulses a frame-start request to the VRAM write (AXI) side.
- Checks line length and line count, and flags FIFO overflow.

Parameters:
- HACT, 1024, active pixels per line
- VACT, 768, active lines per frame
- VS_POL, 0, VSYNC active level (0 = active-low, 1 = active-high)

Ports:
- PCK  input  1  pixel clock
- PRST  input  1  asynchronous active-high reset
- CAP_ON  input  1  capture enable, sampled only at frame start
- VIN_R, VIN_G, VIN_B  input  8 each  source pixel data
- VIN_DE  input  1  source data enable
- VIN_VS  input  1  source vertical sync, polarity per VS_POL
- FIFO_FULL  input  1  pixel FIFO full flag
- FIFO_WRITE  output  1  FIFO write strobe
- FIFO_IN  output  24  {R,G,B} write data
- AXI_WSTART  output  1  one-cycle frame-start pulse to VRAM writer
- PIX_CNT  output  $clog2(HACT+1)  pixel index within current line
- LINE_CNT  output  $clog2(VACT+1)  completed lines in current frame
- OVF_CLR  input  1  clears OVERFLOW
- OVERFLOW  output  1  sticky, pixel dropped on FIFO_FULL
- FRAME_ERR  output  1  sticky per frame, geometry mismatch

Behaviour:
- Reset: PRST asserted at any time forces every output to 0 immediately, state to IDLE and input registers to 0; any in-progress frame is abandoned.
- Stage 1 registers VIN_* (r1). Stage 2 registers r1 into the outputs. Latency from VIN pixel to FIFO_IN/FIFO_WRITE is exactly 2 PCK.
- VS edge: vs_act = r1_VS XNOR VS_POL. Frame start = vs_act 1 this cycle and 0 the previous cycle.
- FSM transitions:
  - IDLE -> WAIT_VS when out of reset.
  - WAIT_VS: at frame start, if CAP_ON=1, pulse AXI_START-style AXI_WSTART for 1 cycle (same cycle as the stage-2 update), clear LINE_CNT, PIX_CNT and FRAME_ERR, then go to WAIT_DE. If CAP_ON=0, stay in WAIT_VS.
  - WAIT_DE -> ACTIVE on r1_DE=1; that first pixel is counted.
  - ACTIVE: PIX_CNT increments per DE pixel. On r1_DE falling, if PIX_CNT != HACT set FRAME_ERR. Then increment LINE_CNT, clear PIX_CNT and return to WAIT_DE.
  - At any frame start while in WAIT_DE or ACTIVE: if LINE_CNT != VACT set FRAME_ERR. If that start occurs mid-line, the partial line is counted as a short line and FRAME_ERR is set. Then re-arm as in WAIT_VS, honouring CAP_ON; if CAP_ON=0, go to WAIT_VS with no pulse.
- Excess data: DE pixels beyond HACT in a line, or lines beyond VACT, are not written. FRAME_ERR is set. PIX_CNT and LINE_CNT saturate at HACT and VACT.
- Write rule:
  - FIFO_WRITE = 1 iff in ACTIVE, r1_DE=1, within HACT/VACT limits, and FIFO_FULL=0 (as sampled in the same cycle as r1).
  - If FIFO_FULL=1, the pixel is dropped (no write) and OVERFLOW is set.
  - FIFO_IN holds the r1 pixel whenever FIFO_WRITE=1, else 0.
- OVERFLOW: sticky until OVF_CLR. If OVF_CLR and a new overflow occur in the same cycle, set wins.
- FRAME_ERR: holds until the next armed frame start.
- Frame start with DE=1 in the same cycle: the frame start is processed first, so the pixel counts as pixel 0 of line 0.
- Width rules: counters are unsigned and never wrap. HACT and VACT must be at least 1.

Test Plan:
- Nominal frame: VS_POL=0, CAP_ON=1, VS low pulse, then 768 lines of 1024 DE pixels with a ramp pattern. Expect one AXI_WSTART pulse, exactly 786432 FIFO_WRITEs with data matching input delayed 2 cycles, FRAME_ERR=0, and final LINE_CNT=768.
- CAP_ON=0 at VS edge then raised mid-frame: no AXI_WSTART and no writes until the next VS edge; the following frame captures normally.
- FIFO_FULL forced high for 5 cycles mid-line: exactly 5 pixels dropped, OVERFLOW=1 and it stays 1. An OVF_CLR pulse returns it to 0. An OVF_CLR in the same cycle as a drop leaves it at 1.
- Short line (1023 pixels) at line 10: FRAME_ERR=1 from DE fall onwards, cleared at the next armed VS edge.
- Long line (1030 pixels): only 1024 writes, PIX_CNT saturates at 1024, FRAME_ERR=1.
- PRST asserted asynchronously mid-line (not on a PCK edge): all outputs 0 immediately. After release, no writes occur until the next VS edge with CAP_ON=1.

Source files
------------

// File: rtl/disp_in.sv
// Video capture front end: registers an external RGB/DE/VSYNC stream, pushes active
// pixels into the pixel FIFO and checks frame geometry against HACT x VACT.
module disp_in #(
    parameter int HACT   = 1024,
    parameter int VACT   = 768,
    parameter bit VS_POL = 1'b0
) (
    input  logic                         PCK,
    input  logic                         PRST,
    input  logic                         CAP_ON,
    input  logic [7:0]                   VIN_R,
    input  logic [7:0]                   VIN_G,
    input  logic [7:0]                   VIN_B,
    input  logic                         VIN_DE,
    input  logic                         VIN_VS,
    input  logic                         FIFO_FULL,
    output logic                         FIFO_WRITE,
    output logic [23:0]                  FIFO_IN,
    output logic                         AXI_WSTART,
    output logic [$clog2(HACT+1)-1:0]    PIX_CNT,
    output logic [$clog2(VACT+1)-1:0]    LINE_CNT,
    input  logic                         OVF_CLR,
    output logic                         OVERFLOW,
    output logic                         FRAME_ERR
);
    localparam int PW = $clog2(HACT + 1);
    localparam int LW = $clog2(VACT + 1);
    localparam logic [PW-1:0] HACT_W = PW'(HACT);
    localparam logic [LW-1:0] VACT_W = LW'(VACT);

    typedef enum logic [1:0] {IDLE, WAIT_VS, WAIT_DE, ACTIVE} state_e;

    // Stage 1: input registers (FIFO_FULL travels with the pixel it applies to)
    logic [23:0] r1_rgb_q;
    logic        r1_de_q;
    logic        r1_vs_q;
    logic        r1_full_q;
    logic        vs_prev_q;

    logic        vs_act;
    logic        frame_start;

    // Stage 2: control state and registered outputs
    state_e      state_q, state_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [LW-1:0] line_q, line_d;
    logic        err_q, err_d;
    logic        ovf_q, ovf_d;
    logic        wr_q, wr_d;
    logic [23:0] data_q, data_d;
    logic        wstart_q, wstart_d;

    assign vs_act      = r1_vs_q ~^ VS_POL;
    assign frame_start = vs_act && !vs_prev_q;

    always_ff @(posedge PCK or posedge PRST) begin
        if (PRST) begin
            r1_rgb_q  <= '0;
            r1_de_q   <= 1'b0;
            r1_vs_q   <= 1'b0;
            r1_full_q <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            r1_rgb_q  <= {VIN_R, VIN_G, VIN_B};
            r1_de_q   <= VIN_DE;
            r1_vs_q   <= VIN_VS;
            r1_full_q <= FIFO_FULL;
            vs_prev_q <= vs_act;
        end
    end

    always_ff @(posedge PCK or posedge PRST) begin
        if (PRST) begin
            state_q  <= IDLE;
            pix_q    <= '0;
            line_q   <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            wr_q     <= 1'b0;
            data_q   <= '0;
            wstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pix_q    <= pix_d;
            line_q   <= line_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            wr_q     <= wr_d;
            data_q   <= data_d;
            wstart_q <= wstart_d;
        end
    end

    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches);
    // later statements then refine the _d values in order, which is why they use '='.
    always_comb begin
        state_d  = state_q;
        pix_d    = pix_q;
        line_d   = line_q;
        err_d    = err_q;
        ovf_d    = ovf_q && !OVF_CLR;
        wr_d     = 1'b0;
        data_d   = '0;
        wstart_d = 1'b0;

        if (state_q == IDLE) begin
            state_d = WAIT_VS;
        end else if (frame_start) begin
            // Close out the running frame: a line cut by VSYNC counts as a short line.
            if (state_q == ACTIVE) begin
                err_d = 1'b1;
                pix_d = '0;
                if (line_d != VACT_W) line_d = line_d + 1'b1;
            end
            if (state_q != WAIT_VS && line_d != VACT_W) err_d = 1'b1;
            if (CAP_ON) begin
                wstart_d = 1'b1;
                pix_d    = '0;
                line_d   = '0;
                err_d    = 1'b0;
                state_d  = WAIT_DE;
            end else begin
                state_d  = WAIT_VS;
            end
        end

        // Runs after frame-start handling so a DE pixel on the VSYNC edge is pixel 0.
        if (state_d == WAIT_DE && r1_de_q) state_d = ACTIVE;

        if (state_d == ACTIVE) begin
            if (r1_de_q) begin
                if (pix_d != HACT_W && line_d != VACT_W) begin
                    if (r1_full_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_d   = 1'b1;
                        data_d = r1_rgb_q;
                    end
                    pix_d = pix_d + 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                if (pix_d != HACT_W) err_d = 1'b1;
                if (line_d != VACT_W) line_d = line_d + 1'b1;
                pix_d   = '0;
                state_d = WAIT_DE;
            end
        end
    end

    assign FIFO_WRITE = wr_q;
    assign FIFO_IN    = data_q;
    assign AXI_WSTART = wstart_q;
    assign PIX_CNT    = pix_q;
    assign LINE_CNT   = line_q;
    assign OVERFLOW   = ovf_q;
    assign FRAME_ERR  = err_q;

endmodule

// File: tb/tb_disp_in.sv
// Directed bench for disp_in on a reduced 8x4 frame: latency, capture gating,
// overflow, geometry errors and asynchronous reset.
module tb_disp_in;
    localparam int HACT = 8;
    localparam int VACT = 4;

    logic        PCK = 1'b0;
    logic        PRST = 1'b1;
    logic        CAP_ON = 1'b1;
    logic [7:0]  VIN_R = '0, VIN_G = '0, VIN_B = '0;
    logic        VIN_DE = 1'b0;
    logic        VIN_VS = 1'b1;
    logic        FIFO_FULL = 1'b0;
    logic        OVF_CLR = 1'b0;
    logic        FIFO_WRITE;
    logic [23:0] FIFO_IN;
    logic        AXI_WSTART;
    logic [3:0]  PIX_CNT;
    logic [2:0]  LINE_CNT;
    logic        OVERFLOW;
    logic        FRAME_ERR;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int ws_cnt = 0;
    int first_wr_cyc = -1;
    logic [23:0] wq[$];

    disp_in #(.HACT(HACT), .VACT(VACT), .VS_POL(1'b0)) dut (
        .PCK(PCK), .PRST(PRST), .CAP_ON(CAP_ON),
        .VIN_R(VIN_R), .VIN_G(VIN_G), .VIN_B(VIN_B),
        .VIN_DE(VIN_DE), .VIN_VS(VIN_VS), .FIFO_FULL(FIFO_FULL),
        .FIFO_WRITE(FIFO_WRITE), .FIFO_IN(FIFO_IN), .AXI_WSTART(AXI_WSTART),
        .PIX_CNT(PIX_CNT), .LINE_CNT(LINE_CNT), .OVF_CLR(OVF_CLR),
        .OVERFLOW(OVERFLOW), .FRAME_ERR(FRAME_ERR)
    );

    always #5 PCK = ~PCK;

    always @(posedge PCK) cyc <= cyc + 1;

    always @(negedge PCK) begin
        if (FIFO_WRITE) begin
            if (wq.size() == 0) first_wr_cyc = cyc;
            wq.push_back(FIFO_IN);
            wr_cnt++;
        end
        if (AXI_WSTART) ws_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] px(input int ln, input int i);
        return {8'(ln), 8'(i), 8'hA5};
    endfunction

    task automatic drv(input logic de, input logic vs, input logic full,
                       input logic clr, input logic [23:0] d);
        VIN_DE = de; VIN_VS = vs; FIFO_FULL = full; OVF_CLR = clr;
        {VIN_R, VIN_G, VIN_B} = d;
        @(posedge PCK); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic vs_pulse();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        drv(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic send_line(input int ln, input int n);
        for (int i = 0; i < n; i++) drv(1'b1, 1'b1, 1'b0, 1'b0, px(ln, i));
        idle(2);
    endtask

    initial begin
        int de_cyc, bad, w0, s0;

        // Reset state
        idle(2);
        check("rst_ctrl", {FIFO_WRITE, AXI_WSTART, OVERFLOW, FRAME_ERR}, 4'b0000);
        check("rst_cnt", {PIX_CNT, LINE_CNT}, 7'd0);
        check("rst_data", FIFO_IN, 24'h0);
        #2 PRST = 1'b0;
        idle(3);

        // Frame 1: nominal 8x4 ramp
        wq.delete();
        vs_pulse();
        check("f1_wstart", ws_cnt, 1);
        de_cyc = cyc;
        for (int l = 0; l < VACT; l++) send_line(l, HACT);
        idle(2);
        check("f1_latency", first_wr_cyc - de_cyc, 2);
        check("f1_writes", wr_cnt, 32);
        bad = 0;
        for (int i = 0; i < 32; i++)
            if (i >= wq.size() || wq[i] !== px(i / HACT, i % HACT)) bad++;
        check("f1_data_bad", bad, 0);
        check("f1_line_cnt", LINE_CNT, 4);
        check("f1_pix_cnt", PIX_CNT, 0);
        check("f1_frame_err", FRAME_ERR, 0);
        check("idle_fifo_in", FIFO_IN, 24'h0);

        // Frame 2: FIFO_FULL drops, OVF_CLR behaviour, short line
        wq.delete();
        w0 = wr_cnt;
        vs_pulse();
        check("f2_wstart", ws_cnt, 2);
        for (int i = 0; i < HACT; i++)
            drv(1'b1, 1'b1, (i >= 2 && i <= 6), 1'b0, px(0, i));
        idle(2);
        check("f2_l0_writes", wr_cnt - w0, 3);
        check("f2_l0_order", {wq[0], wq[1], wq[2]} == {px(0, 0), px(0, 1), px(0, 7)}, 1);
        check("ovf_set", OVERFLOW, 1);
        idle(2);
        check("ovf_sticky", OVERFLOW, 1);
        drv(1'b0, 1'b1, 1'b0, 1'b1, 24'h0);
        check("ovf_clr", OVERFLOW, 0);
        idle(1);
        for (int i = 0; i < HACT; i++)
            drv(1'b1, 1'b1, (i == 3), (i == 3 || i == 4), px(1, i));
        idle(2);
        check("ovf_set_wins", OVERFLOW, 1);
        check("f2_l1_err", FRAME_ERR, 0);
        send_line(2, HACT - 1);
        check("short_line_err", FRAME_ERR, 1);
        check("short_line_cnt", LINE_CNT, 3);
        send_line(3, HACT);
        check("f2_writes", wr_cnt - w0, 25);
        check("f2_err_hold", FRAME_ERR, 1);

        // Frame 3: long line saturates, excess line not written
        w0 = wr_cnt;
        vs_pulse();
        check("f3_err_cleared", FRAME_ERR, 0);
        for (int i = 0; i < HACT + 2; i++) drv(1'b1, 1'b1, 1'b0, 1'b0, px(0, i));
        check("long_pix_sat", PIX_CNT, HACT);
        check("long_err", FRAME_ERR, 1);
        idle(2);
        check("long_writes", wr_cnt - w0, HACT);
        for (int l = 1; l <= VACT; l++) send_line(l, HACT);
        check("f3_writes", wr_cnt - w0, 32);
        check("f3_line_sat", LINE_CNT, VACT);

        // Frame 4: CAP_ON low at VSYNC edge, raised mid-frame
        w0 = wr_cnt;
        s0 = ws_cnt;
        CAP_ON = 1'b0;
        vs_pulse();
        CAP_ON = 1'b1;
        send_line(0, HACT);
        send_line(1, HACT);
        check("capoff_no_wstart", ws_cnt - s0, 0);
        check("capoff_no_writes", wr_cnt - w0, 0);
        check("capoff_err_hold", FRAME_ERR, 1);
        vs_pulse();
        check("rearm_wstart", ws_cnt - s0, 1);
        check("rearm_err_clr", FRAME_ERR, 0);

        // Frame 5: asynchronous reset mid-line
        for (int i = 0; i < 5; i++) drv(1'b1, 1'b1, 1'b0, 1'b0, px(0, i));
        check("pre_rst_write", {FIFO_WRITE, PIX_CNT}, {1'b1, 4'd4});
        #3 PRST = 1'b1;
        #1;
        check("async_rst_ctrl", {FIFO_WRITE, AXI_WSTART, OVERFLOW, FRAME_ERR}, 4'b0000);
        check("async_rst_cnt", {PIX_CNT, LINE_CNT}, 7'd0);
        check("async_rst_data", FIFO_IN, 24'h0);
        #2 PRST = 1'b0;
        @(posedge PCK); #1;
        w0 = wr_cnt;
        s0 = ws_cnt;
        for (int i = 5; i < HACT; i++) drv(1'b1, 1'b1, 1'b0, 1'b0, px(0, i));
        idle(2);
        send_line(1, HACT);
        check("post_rst_no_writes", wr_cnt - w0, 0);
        vs_pulse();
        send_line(0, HACT);
        check("post_rst_wstart", ws_cnt - s0, 1);
        check("post_rst_writes", wr_cnt - w0, HACT);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
